// File: rtl/divider.sv
// Sequential 8-bit unsigned restoring divider driven by push-buttons: Q / M -> Q (quotient), R (remainder).
// Inputs pass through 2-flop synchronizers; a division takes 8 cycles in DIV, and divide-by-zero finishes at once.
module divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ClearR_LoadQ,
  input  logic       LoadM,
  input  logic       Run,
  input  logic [7:0] S,
  output logic [7:0] Qval,
  output logic [7:0] Rval,
  output logic [6:0] QhexU,
  output logic [6:0] QhexL,
  output logic [6:0] RhexU,
  output logic [6:0] RhexL,
  output logic       Busy,
  output logic       DivZero
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic [7:0] m_q, m_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       dz_q, dz_d;

  // Synchronizer stages hold active-high button levels, so reset means released.
  logic       loadq_s1_q, loadq_s1_d, loadq_s2_q, loadq_s2_d;
  logic       loadm_s1_q, loadm_s1_d, loadm_s2_q, loadm_s2_d;
  logic       run_s1_q, run_s1_d, run_s2_q, run_s2_d;
  logic [7:0] s_s1_q, s_s1_d, s_s2_q, s_s2_d;

  logic [8:0] trial;
  logic [7:0] trial_sub;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    loadq_s1_d = ~ClearR_LoadQ;
    loadq_s2_d = loadq_s1_q;
    loadm_s1_d = ~LoadM;
    loadm_s2_d = loadm_s1_q;
    run_s1_d   = ~Run;
    run_s2_d   = run_s1_q;
    s_s1_d     = S;
    s_s2_d     = s_s1_q;

    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;

    // R < M holds before every step, so the 9-bit difference always fits in R.
    trial     = {r_q, q_q[7]};
    trial_sub = 8'(trial - {1'b0, m_q});

    case (state_q)
      IDLE: begin
        if (run_s2_q) begin
          if (m_q == 8'd0) begin
            r_d     = q_q;
            q_d     = 8'hFF;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = 8'd0;
            dz_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = DIV;
          end
        end else begin
          if (loadq_s2_q) begin
            q_d = s_s2_q;
            r_d = 8'd0;
          end
          if (loadm_s2_q) begin
            m_d = s_s2_q;
          end
        end
      end
      DIV: begin
        if (trial >= {1'b0, m_q}) begin
          r_d = trial_sub;
          q_d = {q_q[6:0], 1'b1};
        end else begin
          r_d = trial[7:0];
          q_d = {q_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Stay here while Run is held so one press gives exactly one division.
        if (!run_s2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIV);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      q_q        <= 8'd0;
      r_q        <= 8'd0;
      m_q        <= 8'd0;
      cnt_q      <= 3'd0;
      busy_q     <= 1'b0;
      dz_q       <= 1'b0;
      loadq_s1_q <= 1'b0;
      loadq_s2_q <= 1'b0;
      loadm_s1_q <= 1'b0;
      loadm_s2_q <= 1'b0;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      s_s1_q     <= 8'd0;
      s_s2_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      dz_q       <= dz_d;
      loadq_s1_q <= loadq_s1_d;
      loadq_s2_q <= loadq_s2_d;
      loadm_s1_q <= loadm_s1_d;
      loadm_s2_q <= loadm_s2_d;
      run_s1_q   <= run_s1_d;
      run_s2_q   <= run_s2_d;
      s_s1_q     <= s_s1_d;
      s_s2_q     <= s_s2_d;
    end
  end

  assign Qval    = q_q;
  assign Rval    = r_q;
  assign Busy    = busy_q;
  assign DivZero = dz_q;
  assign QhexU   = hex7(q_q[7:4]);
  assign QhexL   = hex7(q_q[3:0]);
  assign RhexU   = hex7(r_q[7:4]);
  assign RhexL   = hex7(r_q[3:0]);

endmodule

// File: tb/tb_divider.sv
// Directed + randomized bench for divider against a plain-arithmetic quotient/remainder model.
module tb_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ClearR_LoadQ = 1'b1;
  logic       LoadM = 1'b1;
  logic       Run = 1'b1;
  logic [7:0] S = 8'd0;
  logic [7:0] Qval, Rval;
  logic [6:0] QhexU, QhexL, RhexU, RhexL;
  logic       Busy, DivZero;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: what Q, R, M and DivZero should be, derived from q/m arithmetic.
  logic [7:0] mq = 8'd0, mr = 8'd0, mm = 8'd0;
  logic       mdz = 1'b0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  divider dut (
    .Clk(Clk), .Reset(Reset), .ClearR_LoadQ(ClearR_LoadQ), .LoadM(LoadM), .Run(Run), .S(S),
    .Qval(Qval), .Rval(Rval), .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL),
    .Busy(Busy), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".q"}, {24'd0, Qval}, {24'd0, mq});
    chk({tag, ".r"}, {24'd0, Rval}, {24'd0, mr});
    chk({tag, ".dz"}, {31'd0, DivZero}, {31'd0, mdz});
    chk({tag, ".busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, ".qhu"}, {25'd0, QhexU}, {25'd0, font[mq[7:4]]});
    chk({tag, ".qhl"}, {25'd0, QhexL}, {25'd0, font[mq[3:0]]});
    chk({tag, ".rhu"}, {25'd0, RhexU}, {25'd0, font[mr[7:4]]});
    chk({tag, ".rhl"}, {25'd0, RhexL}, {25'd0, font[mr[3:0]]});
  endtask

  task automatic load_q(input logic [7:0] v);
    @(posedge Clk); #1;
    S = v;
    ClearR_LoadQ = 1'b0;
    repeat (4) @(posedge Clk);
    #1 ClearR_LoadQ = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    mq = v;
    mr = 8'd0;
  endtask

  task automatic load_m(input logic [7:0] v);
    @(posedge Clk); #1;
    S = v;
    LoadM = 1'b0;
    repeat (4) @(posedge Clk);
    #1 LoadM = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    mm = v;
  endtask

  // Hold Run for 'hold' cycles, counting Busy cycles; optionally jiggle loads while busy.
  task automatic do_run(input string tag, input int hold, input bit toggle);
    int bc;
    bc = 0;
    @(posedge Clk); #1;
    Run = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (Busy) bc++;
      if (toggle && Busy) begin
        ClearR_LoadQ = i[0];
        LoadM = ~i[0];
        S = 8'($urandom);
      end else begin
        ClearR_LoadQ = 1'b1;
        LoadM = 1'b1;
      end
    end
    Run = 1'b1;
    ClearR_LoadQ = 1'b1;
    LoadM = 1'b1;
    repeat (5) @(posedge Clk);
    if (mm == 8'd0) begin
      mr = mq;
      mq = 8'hFF;
      mdz = 1'b1;
    end else begin
      mr = mq % mm;
      mq = mq / mm;
      mdz = 1'b0;
    end
    chk({tag, ".busy_cycles"}, bc, (mm == 8'd0) ? 32'd0 : 32'd8);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  initial begin
    int w;
    logic [7:0] rq, rm;

    // Reset state, then release without any stimulus.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_outputs("reset");
    #2 Reset = 1'b1;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    check_outputs("post_reset");

    load_q(8'd100);
    load_m(8'd7);
    do_run("d100_7", 20, 1'b0);
    chk("d100_7.q_const", {24'd0, Qval}, 32'h0E);
    chk("d100_7.r_const", {24'd0, Rval}, 32'h02);

    load_q(8'hFF); load_m(8'h01); do_run("dFF_1", 20, 1'b0);
    load_q(8'h07); load_m(8'h09); do_run("d07_9", 20, 1'b0);

    load_q(8'h2A); load_m(8'h00); do_run("dz", 20, 1'b0);
    chk("dz.r_const", {24'd0, Rval}, 32'h2A);
    load_m(8'd5); do_run("after_dz", 20, 1'b0);

    load_q(8'd200); load_m(8'd3); do_run("d200_3", 20, 1'b0);
    do_run("chain", 20, 1'b0);
    chk("chain.q_const", {24'd0, Qval}, 32'h16);

    for (int k = 0; k < 6; k++) begin
      rq = 8'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      load_q(rq);
      load_m(rm);
      do_run($sformatf("rand%0d", k), 20, 1'b0);
    end

    // Long hold with load buttons toggled during DIV; M must survive.
    load_q(8'hC8); load_m(8'h0B);
    do_run("held50", 50, 1'b1);
    load_q(8'h99);
    do_run("m_kept", 20, 1'b0);

    // Asynchronous reset in the fourth DIV cycle.
    load_q(8'hAB); load_m(8'h05);
    @(posedge Clk); #1 Run = 1'b0;
    w = 0;
    while (!Busy && w < 10) begin
      @(negedge Clk);
      w++;
    end
    chk("abort.busy_start", {31'd0, Busy}, 32'd1);
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    Run = 1'b1;
    #1;
    mq = 8'd0; mr = 8'd0; mm = 8'd0; mdz = 1'b0;
    check_outputs("abort");
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;
    load_q(8'h09);
    do_run("abort_m_cleared", 20, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Clk  input  1  system clock; all state on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; raw push-button.
REQ-003 ClearR_LoadQ  input  1  active-low push-button; loads dividend.
REQ-004 LoadM  input  1  active-low push-button; loads divisor.
REQ-005 Run  input  1  active-low push-button; starts division.
REQ-006 S  input  8  slider switches; operand data.
REQ-007 Qval  output  8  quotient register Q.
REQ-008 Rval  output  8  remainder register R.
REQ-009 QhexU, QhexL, RhexU, RhexL  output  7 each  active-low seven-segment codes of Q[7:4], Q[3:0], R[7:4], R[3:0].
REQ-010 Busy  output  1  high while division iterations run.
REQ-011 DivZero  output  1  high when the last Run had divisor 0.

Function
REQ-012 ClearR_LoadQ, LoadM, Run and S SHALL each pass through a two-flop synchronizer; button outputs inverted to active-high; all behaviour below is defined on synchronized signals (2-cycle input latency).
REQ-013 Internal 8-bit divisor register M; Q, R, M unsigned.
REQ-014 FSM states: IDLE, DIV, DONE.
REQ-015 IDLE, Run high: M==0 -> R<=Q, Q<=8'hFF, DivZero<=1, go DONE; else R<=0, DivZero<=0, counter<=0, go DIV.
REQ-016 IDLE, Run low: ClearR_LoadQ high -> Q<=S, R<=0; LoadM high -> M<=S; both high -> both loads same cycle.
REQ-017 Loads SHALL be ignored in DIV and DONE, and in IDLE on a cycle where Run is high.
REQ-018 DIV, one iteration per cycle: T={R,Q[7]} (9 bits); T>=M -> R<=T-M, Q<={Q[6:0],1}; else R<=T[7:0], Q<={Q[6:0],0}.
REQ-019 Subtraction SHALL be 9-bit; result always fits in 8 bits since R<M before each iteration.
REQ-020 3-bit counter increments per DIV cycle; DIV with counter==7 -> DONE after that iteration (exactly 8 DIV cycles).
REQ-021 Busy SHALL be high exactly in DIV (registered state decode); Q, R final on first cycle Busy is low.
REQ-022 DONE holds Q, R, DivZero; Run low -> IDLE; Run held indefinitely -> remain DONE (one division per press).
REQ-023 Run pressed again from IDLE SHALL divide current Q by M (chaining); DivZero stays at last-run value until next Run.
REQ-024 Hex outputs combinational from Q/R: 0->7'b1000000, 1->7'b1111001, ..., F->7'b0001110 (standard active-low hex font).
REQ-025 M, Q, R, counter unchanged by button activity during DIV.

Reset
REQ-026 Reset low SHALL asynchronously force: state IDLE, Q=0, R=0, M=0, counter=0, Busy=0, DivZero=0, synchronizer flops=0 (buttons released).
REQ-027 Reset mid-DIV or mid-DONE SHALL abort immediately; no partial result retained.
REQ-028 After reset, hex outputs all 7'b1000000.
REQ-029 Release of Reset SHALL not by itself start a division or load.

Verification
REQ-030 S=100 load Q, S=7 load M, Run -> Busy high 8 cycles, Qval=0x0E, Rval=0x02, DivZero=0.
REQ-031 Q=0xFF, M=0x01, Run -> Qval=0xFF, Rval=0x00; Q=0x07, M=0x09 -> Qval=0x00, Rval=0x07.
REQ-032 Q=0x2A, M=0, Run -> no Busy, DONE next cycle, Qval=0xFF, Rval=0x2A, DivZero=1; then M=5, Run -> DivZero=0.
REQ-033 Q=200, M=3, Run -> Qval=0x42, Rval=0x02; release, Run again -> Qval=0x16, Rval=0x00.
REQ-034 Run held 50 cycles -> exactly one division; LoadM/ClearR_LoadQ toggled during DIV -> M, result unaffected.
REQ-035 Reset asserted at DIV cycle 4 -> Q, R, M, Busy, DivZero = 0 immediately; hex = 7'b1000000.
